io_input_cond: RTL
==================

Name: io_input_cond

Overview:
Input conditioning stage that sits directly upstream of the load/store unit's input buffer. It takes raw board switches and push-buttons, synchronises them into the core clock domain, debounces them and normalises polarity. It drives the LSU's switch-word and button-nibble inputs, plus one-cycle press/release event pulses for later interrupt or counter use. A load of the input region therefore always returns clean, glitch-free, active-high values.

Parameters:
TICK_DIV, 50000, core cycles per debounce sample tick (1 ms at 50 MHz); must be >= 2
DB_TICKS, 10, consecutive stable ticks required to accept a button change; must be >= 1
BTN_ACTIVE_LOW, 1, 1 = raw buttons read 0 when pressed (board default); 0 = active-high
NUM_BTN, 4, number of push-buttons

Ports:
clk_i  input  1  core clock
rst_i  input  1  asynchronous, active-high reset
sw_async_i  input  32  raw slide switches, asynchronous to clk_i
btn_async_i  input  NUM_BTN  raw push-buttons, asynchronous, polarity per BTN_ACTIVE_LOW
io_sw_o  output  32  filtered switch word; feeds the LSU switch input
io_btn_o  output  NUM_BTN  debounced buttons, 1 = pressed; feeds the LSU button input
btn_press_o  output  NUM_BTN  one-cycle pulse per accepted press
btn_release_o  output  NUM_BTN  one-cycle pulse per accepted release
tick_o  output  1  sample-tick strobe, exposed for verification

Behaviour:
- Reset (async, active-high): every flop clears to 0.
  - All outputs read 0; prescaler = 0; every button FSM = IDLE.
  - Asserting reset mid-operation discards any partial debounce immediately.
- Polarity: buttons are inverted ahead of the sync flops when BTN_ACTIVE_LOW=1. From that point on, all internal logic is active-high.
- Sync: 2-FF synchroniser on all 32+NUM_BTN bits; 2 cycles of latency.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick_o = 1 for exactly one cycle when count == TICK_DIV-1.
  - First tick falls TICK_DIV cycles after reset release.
- Switch filter (per bit):
  - On each tick, sw_prev <= sw_sync.
  - If sw_sync == sw_prev at that tick, io_sw_o bit <= sw_sync; otherwise it holds.
  - A new value appears within 2 + 2*TICK_DIV cycles of being applied.
  - A glitch shorter than TICK_DIV cycles never propagates.
- Button FSM (per button): states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT; counter cnt of width clog2(DB_TICKS).
  - IDLE: sync=1 -> PRESS_WAIT with cnt=0.
  - PRESS_WAIT:
    - sync=0 -> IDLE with cnt=0 (abort).
    - Else, on tick: if cnt == DB_TICKS-1 -> HELD, otherwise cnt++.
  - HELD: sync=0 -> RELEASE_WAIT with cnt=0.
  - RELEASE_WAIT: mirror of PRESS_WAIT (sync=1 aborts to HELD; DB_TICKS stable ticks -> IDLE).
  - Abort takes priority over a tick in the same cycle.
- Button outputs (all registered):
  - io_btn_o = 1 in HELD and RELEASE_WAIT.
  - btn_press_o pulses in the first cycle io_btn_o reads 1.
  - btn_release_o pulses in the first cycle io_btn_o reads 0 after HELD.
  - Press and release never pulse together for the same button; different buttons are fully independent.
- Press latency after the raw edge: 2 + (DB_TICKS-1)*TICK_DIV + 1 .. 2 + DB_TICKS*TICK_DIV + 1 cycles. Release latency is symmetric.
- Button held through reset: after reset release it runs a full debounce and produces one press pulse.
- Counter saturation: cnt never exceeds DB_TICKS-1; the prescaler never exceeds TICK_DIV-1.

Decomposition:
- Package io_cond_pkg:
  - enum db_state_e {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT}
  - default constants for TICK_DIV and DB_TICKS
  - simulation constants SIM_TICK_DIV=4, SIM_DB_TICKS=3
- Sub-module btn_debounce: one FSM, counter and pulse generator per button, instantiated NUM_BTN times via generate.
- Prescaler, synchroniser and switch filter live in the top level.

Test Plan (TICK_DIV=4, DB_TICKS=3, BTN_ACTIVE_LOW=1):
1. Reset with btn_async_i=4'hF, sw_async_i=0, then release and run 100 cycles -> all outputs 0; tick_o fires every 4 cycles starting 4 cycles after release.
2. Drive btn_async_i=4'hE and hold -> io_btn_o=4'h1 between 11 and 15 cycles later; btn_press_o=4'h1 for exactly one cycle in that same cycle; no other bits change.
3. Toggle btn1 every 3 cycles for 30 cycles, then 4'hF -> io_btn_o[1] stays 0; btn_press_o and btn_release_o stay 0.
4. From the held state of test 2, drive 4'hF -> io_btn_o falls to 0 within 11-15 cycles, with btn_release_o[0] one-cycle pulse coincident.
5. Drive sw_async_i=32'hDEADBEEF -> io_sw_o=32'hDEADBEEF within 10 cycles; a 1-cycle 32'h0 glitch around a tick leaves io_sw_o unchanged.
6. Assert rst_i asynchronously (mid-cycle) while btn0 is in PRESS_WAIT -> all outputs 0 with no clock edge. Release reset with btn0 still pressed -> exactly one press pulse after a full debounce.

Source files
------------

// File: rtl/io_cond_pkg.sv
// Shared types and constants for the board input conditioning stage.
package io_cond_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_e;

    localparam int unsigned DEF_TICK_DIV = 50000;
    localparam int unsigned DEF_DB_TICKS = 10;
    localparam int unsigned SIM_TICK_DIV = 4;
    localparam int unsigned SIM_DB_TICKS = 3;
    localparam int unsigned SW_W         = 32;

    // Counter width that stays legal for a modulus of 1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button debouncer: stable-tick counting FSM with registered level and edge pulses.
module btn_debounce
    import io_cond_pkg::*;
#(
    parameter int unsigned DB_TICKS = DEF_DB_TICKS
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sync_i,
    input  logic tick_i,
    output logic btn_o,
    output logic press_o,
    output logic release_o
);

    localparam int unsigned   CW      = cnt_width(DB_TICKS);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_TICKS - 1);

    db_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic          btn_q;
    logic          press_q;
    logic          release_q;

    // An input change that drops out before the tick count completes aborts back.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            btn_q     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sync_i) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync_i) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (tick_i) begin
                        if (cnt_q == CNT_MAX) begin
                            state_q <= HELD;
                            cnt_q   <= '0;
                            btn_q   <= 1'b1;
                            press_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                HELD: begin
                    if (!sync_i) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (sync_i) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                    end else if (tick_i) begin
                        if (cnt_q == CNT_MAX) begin
                            state_q   <= IDLE;
                            cnt_q     <= '0;
                            btn_q     <= 1'b0;
                            release_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign btn_o     = btn_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/io_input_cond.sv
// Board switch/button conditioning: polarity fix, 2-FF sync, tick prescaler,
// switch majority-of-two filter and per-button debouncers.
module io_input_cond
    import io_cond_pkg::*;
#(
    parameter int unsigned TICK_DIV       = DEF_TICK_DIV,
    parameter int unsigned DB_TICKS       = DEF_DB_TICKS,
    parameter bit          BTN_ACTIVE_LOW = 1'b1,
    parameter int unsigned NUM_BTN        = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [SW_W-1:0]    sw_async_i,
    input  logic [NUM_BTN-1:0] btn_async_i,
    output logic [SW_W-1:0]    io_sw_o,
    output logic [NUM_BTN-1:0] io_btn_o,
    output logic [NUM_BTN-1:0] btn_press_o,
    output logic [NUM_BTN-1:0] btn_release_o,
    output logic               tick_o
);

    localparam int unsigned   PW      = cnt_width(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    logic [NUM_BTN-1:0] btn_pol;
    logic [NUM_BTN-1:0] btn_meta_q;
    logic [NUM_BTN-1:0] btn_sync_q;
    logic [SW_W-1:0]    sw_meta_q;
    logic [SW_W-1:0]    sw_sync_q;
    logic [SW_W-1:0]    sw_prev_q;
    logic [SW_W-1:0]    sw_flt_q;
    logic [SW_W-1:0]    sw_flt_d;
    logic [SW_W-1:0]    sw_diff;
    logic [PW-1:0]      pre_q;
    logic [PW-1:0]      pre_d;
    logic               tick_q;

    // Everything downstream of this point treats 1 as pressed.
    assign btn_pol = BTN_ACTIVE_LOW ? ~btn_async_i : btn_async_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            btn_meta_q <= '0;
            btn_sync_q <= '0;
        end else begin
            sw_meta_q  <= sw_async_i;
            sw_sync_q  <= sw_meta_q;
            btn_meta_q <= btn_pol;
            btn_sync_q <= btn_meta_q;
        end
    end

    // tick_q is high exactly while the prescaler sits at its terminal count.
    assign pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + PW'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= (pre_d == PRE_MAX);
        end
    end

    // A switch bit is accepted only when two consecutive tick samples agree.
    assign sw_diff  = sw_sync_q ^ sw_prev_q;
    assign sw_flt_d = tick_q ? ((sw_sync_q & ~sw_diff) | (sw_flt_q & sw_diff)) : sw_flt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sw_prev_q <= '0;
            sw_flt_q  <= '0;
        end else begin
            if (tick_q) begin
                sw_prev_q <= sw_sync_q;
            end
            sw_flt_q <= sw_flt_d;
        end
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(
            .DB_TICKS (DB_TICKS)
        ) u_db (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .sync_i    (btn_sync_q[g]),
            .tick_i    (tick_q),
            .btn_o     (io_btn_o[g]),
            .press_o   (btn_press_o[g]),
            .release_o (btn_release_o[g])
        );
    end

    assign io_sw_o = sw_flt_q;
    assign tick_o  = tick_q;

endmodule
